// File: rtl/audio_pkg.sv
// Shared audio-path types for the tone generator to codec chain.
package audio_pkg;

  localparam int SAMPLE_W = 24;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic {RUN, CLEAR} avg_state_t;

endpackage

// File: rtl/avg_history_buf.sv
// N-entry sample history: one async read port, one write port.
// Read is combinational; reset zeroes every entry, the owner clears entries by writing zero.
module avg_history_buf #(
  parameter int DATA_W     = 24,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en_i,
  input  logic [DEPTH_LOG2-1:0] wr_addr_i,
  input  logic [DATA_W-1:0]     wr_data_i,
  input  logic [DEPTH_LOG2-1:0] rd_addr_i,
  output logic [DATA_W-1:0]     rd_data_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/moving_avg_out_stage.sv
// N-tap running moving average of signed samples feeding the codec write port.
// 1-cycle latency; single-stage pipe, in_ready drops while the output is stalled or history is clearing.
module moving_avg_out_stage
  import audio_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W,
  parameter int LOG2_N = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
);

  localparam int N = 1 << LOG2_N;
  localparam logic [LOG2_N-1:0] LAST_IDX = LOG2_N'(N - 1);

  avg_state_t               state_q, state_d;
  logic [LOG2_N-1:0]        wr_ptr_q, wr_ptr_d;
  logic [LOG2_N-1:0]        clr_cnt_q, clr_cnt_d;
  logic signed [DATA_W-1:0] acc_q, acc_d;
  logic signed [DATA_W-1:0] out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;

  logic signed [DATA_W-1:0] scaled, oldest, sum;
  logic                     in_fire, hist_we;
  logic [LOG2_N-1:0]        hist_addr;
  logic [DATA_W-1:0]        hist_wdata, hist_rdata;

  // Pre-scaling each sample keeps the 8-term sum inside DATA_W.
  assign scaled = $signed(in_data) >>> LOG2_N;
  assign oldest = $signed(hist_rdata);
  assign sum    = acc_q + scaled - oldest;

  avg_history_buf #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (LOG2_N)
  ) u_hist (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en_i   (hist_we),
    .wr_addr_i (hist_addr),
    .wr_data_i (hist_wdata),
    .rd_addr_i (wr_ptr_q),
    .rd_data_o (hist_rdata)
  );

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    clr_cnt_d   = clr_cnt_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    hist_we     = 1'b0;
    hist_addr   = wr_ptr_q;
    hist_wdata  = scaled;
    // Gating by flush keeps upstream from believing a flushed sample was taken.
    in_ready    = (state_q == RUN) && !flush && (!out_valid_q || out_ready);
    in_fire     = in_valid && in_ready;

    if (flush) begin
      state_d     = CLEAR;
      clr_cnt_d   = '0;
      wr_ptr_d    = '0;
      acc_d       = '0;
      out_data_d  = '0;
      out_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (in_fire) begin
            hist_we     = 1'b1;
            acc_d       = sum;
            out_data_d  = sum;
            out_valid_d = 1'b1;
            wr_ptr_d    = wr_ptr_q + 1'b1;
          end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
          end
        end
        CLEAR: begin
          hist_we    = 1'b1;
          hist_addr  = clr_cnt_q;
          hist_wdata = '0;
          clr_cnt_d  = clr_cnt_q + 1'b1;
          if (clr_cnt_q == LAST_IDX) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RUN;
      wr_ptr_q    <= '0;
      clr_cnt_q   <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      clr_cnt_q   <= clr_cnt_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_moving_avg_out_stage.sv
// Directed bench for the moving-average output stage with a sum-of-last-8 reference.
module tb_moving_avg_out_stage;
  import audio_pkg::*;

  logic    clk = 1'b0;
  logic    reset_n, flush, in_valid, in_ready, out_valid, out_ready;
  sample_t in_data, out_data;

  int vectors = 0;
  int miscompares = 0;

  int mh[$];
  int m_od;
  bit m_ov;
  int rom[64];

  always #5 clk = ~clk;

  moving_avg_out_stage #(.DATA_W(24), .LOG2_N(3)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Floor division by 8, written without a shift.
  function automatic int scale8(input int d);
    return (d >= 0) ? d / 8 : -((-d + 7) / 8);
  endfunction

  task automatic model_clear();
    mh.delete();
    m_od = 0;
    m_ov = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #2;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    @(negedge clk);
    reset_n = 1'b1;
    model_clear();
  endtask

  task automatic drive(input bit v, input int d, input bit ordy, output bit fired);
    bit exp_rdy;
    int s;
    in_valid  = v;
    in_data   = sample_t'(d);
    out_ready = ordy;
    flush     = 1'b0;
    #1;
    exp_rdy = !m_ov || ordy;
    check("in_ready", int'(in_ready), int'(exp_rdy));
    fired = v && exp_rdy;
    tick();
    if (fired) begin
      mh.push_back(scale8(d));
      if (mh.size() > 8) void'(mh.pop_front());
      s = 0;
      foreach (mh[i]) s += mh[i];
      m_od = s;
      m_ov = 1'b1;
    end else if (m_ov && ordy) begin
      m_ov = 1'b0;
    end
    check("out_valid", int'(out_valid), int'(m_ov));
    check("out_data", int'(out_data), m_od);
  endtask

  initial begin
    bit f;
    bit req_v;
    bit ordy;
    int idx;
    int got;

    for (int k = 0; k < 64; k++)
      rom[k] = ((k < 32) ? k : 63 - k) * 260000 - 4000000 + k * 7 - 3;

    // Ramp at 800: 100..800 then steady, then drain.
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 800, 1'b1, f);
      check("ramp800", int'(out_data), ((i < 8) ? i : 8) * 100);
    end
    drive(1'b0, 0, 1'b1, f);
    check("drain_valid", int'(out_valid), 0);

    // Negative input: sign-extended shift gives -1 per sample.
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, -8, 1'b1, f);
      check("neg8", int'(out_data), -((i < 8) ? i : 8));
    end

    // 7 truncates to 0; then 8 ramps 1..8.
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 7, 1'b1, f);
      check("trunc7", int'(out_data), 0);
    end
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 8, 1'b1, f);
      check("ramp8", int'(out_data), i);
    end

    // Backpressure: stall 5 cycles at steady 800, then release with mixed out_ready.
    do_reset();
    for (int i = 0; i < 8; i++) drive(1'b1, 800, 1'b1, f);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 800, 1'b0, f);
      check("stall_ready", int'(in_ready), 0);
      check("stall_data", int'(out_data), 800);
    end
    for (int i = 0; i < 12; i++) drive(1'b1, 1600 + i * 80, (i % 3) != 2, f);

    // Flush at steady 800: 8 clear cycles, then restart from empty history.
    for (int i = 0; i < 8; i++) drive(1'b1, 800, 1'b1, f);
    check("pre_flush", int'(out_data), 800);
    in_valid  = 1'b1;
    in_data   = sample_t'(800);
    out_ready = 1'b1;
    flush     = 1'b1;
    #1;
    check("flush_ready", int'(in_ready), 0);
    tick();
    flush = 1'b0;
    model_clear();
    check("flush_valid", int'(out_valid), 0);
    check("flush_data", int'(out_data), 0);
    for (int i = 0; i < 8; i++) begin
      #1;
      check("clr_ready", int'(in_ready), 0);
      check("clr_valid", int'(out_valid), 0);
      tick();
    end
    drive(1'b1, 800, 1'b1, f);
    check("post_flush", int'(out_data), 100);

    // Asynchronous reset between clock edges.
    for (int i = 0; i < 3; i++) drive(1'b1, 800, 1'b1, f);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_valid", int'(out_valid), 0);
    check("arst_data", int'(out_data), 0);
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_clear();
    drive(1'b1, 800, 1'b1, f);
    check("post_arst", int'(out_data), 100);

    // Tone-generator traffic: data valid one cycle after each request.
    do_reset();
    req_v = 1'b0;
    idx   = 0;
    got   = 0;
    for (int cyc = 0; cyc < 4000 && got < 530; cyc++) begin
      ordy = ($urandom_range(3) != 0);
      drive(req_v, req_v ? rom[idx % 64] : 0, ordy, f);
      if (f) begin
        got++;
        idx++;
      end
      req_v = (req_v && !f) ? 1'b1 : ($urandom_range(7) != 0);
    end
    check("tone_count", got, 530);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/moving_avg_out_stage.md
Name: moving_avg_out_stage

Overview:
- Downstream of the ROM-based tone generator; consumes its 24-bit signed samples and produces an N-tap moving average for the audio codec write path.
- Keeps an N-deep circular history of pre-scaled samples and a running accumulator, so one input produces one output with no multi-cycle summation.
- Upstream side is valid/ready. Downstream side is valid/ready matching the codec's write / write_ready.

Parameters:
- DATA_W, 24, sample width in bits (two's complement).
- LOG2_N, 3, log2 of the tap count; N = 2**LOG2_N = 8.

Ports:
- clk  in  1  single clock for the block.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of history, accumulator and output register.
- in_valid  in  1  in_data holds a sample this cycle.
- in_data  in  DATA_W  signed input sample.
- in_ready  out  1  block accepts in_data this cycle.
- out_valid  out  1  out_data holds a filtered sample; drives the codec write.
- out_data  out  DATA_W  signed moving-average sample.
- out_ready  in  1  the codec accepts out_data this cycle (write_ready).

Behaviour:
- Reset (reset_n=0, async):
  - history RAM entries = 0, wr_ptr = 0, acc = 0.
  - out_valid = 0, out_data = 0.
- in_ready = !out_valid || out_ready. This is a combinational single-stage pipe; there is no skid buffer.
- Accept: in_fire = in_valid && in_ready.
- Scaling: scaled = in_data >>> LOG2_N. This is an arithmetic shift with sign extension, truncating toward -inf (e.g. -1 -> -1, 7 -> 0).
- On in_fire:
  - oldest = hist[wr_ptr].
  - hist[wr_ptr] <= scaled.
  - acc <= acc + scaled - oldest, computed mod 2^DATA_W. The true sum always fits in DATA_W, so no saturation is needed.
  - out_data <= acc + scaled - oldest; out_valid <= 1.
  - wr_ptr <= wr_ptr + 1, wrapping N-1 -> 0.
- Latency: 1 cycle from in_fire to out_valid=1 with that sample's result.
- Output handshake:
  - out_valid && out_ready without a new in_fire -> out_valid <= 0.
  - Accept and drain in the same cycle -> out_valid stays 1 and out_data takes the new value.
  - out_valid && !out_ready -> out_data and out_valid hold stable and in_ready = 0.
- Warm-up: history starts at zero, so the first N-1 outputs ramp. No separate primed state exists.
- flush=1 (sync, overrides in_fire in the same cycle):
  - hist is cleared over N cycles by a clear-counter sweep. While clearing, in_ready = 0.
  - acc = 0, out_valid = 0, wr_ptr = 0.
  - A flush asserted during a sweep restarts the sweep.
- FSM states: RUN and CLEAR.
  - RUN -> CLEAR on flush.
  - CLEAR -> RUN after the clear counter reaches N-1.
  - Reset enters RUN directly, because async reset zeroes the registers.
- Reset mid-operation: all state returns to reset values immediately. In-flight output is discarded.

Decomposition:
- Package audio_pkg holds:
  - localparam SAMPLE_W = 24.
  - typedef logic signed [SAMPLE_W-1:0] sample_t.
  - typedef enum {RUN, CLEAR} avg_state_t.
- One sub-module, avg_history_buf: N x DATA_W register file with a read port at the write pointer and a write port. It is reset by reset_n and cleared by the sweep.

Test Plan:
- Reset, then feed 800 continuously with out_ready=1 -> out_data = 100, 200, …, 800 on successive cycles, then 800 steady; out_valid=1 each cycle after the first accept.
- Feed -8 ×10 -> outputs -1, -2, …, -8, -8, -8 (checks sign-extended shift).
- Feed 7 ×8 -> all outputs 0 (truncation); then 8 ×8 -> 1..8.
- After warm-up at 800, hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out_data=800 stable. On release, the next inputs are consumed one per cycle and no sample is lost or duplicated; the output sequence is checked against a reference model.
- Assert flush for 1 cycle at steady 800 -> in_ready=0 for 8 cycles, out_valid=0; then input 800 -> output 100.
- Drop reset_n mid-stream, asynchronously between clock edges -> out_valid=0 and out_data=0 immediately; after release, input 800 -> output 100.
- Feed tone-generator-style data (ROM values, in_valid one cycle after the request) for 530 samples -> outputs match the software moving-average model bit-exactly, including the ptr wrap.
